// File: rtl/isqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square-root engine.
package isqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Iteration counter width; never narrower than one bit.
   function automatic int cnt_w(input int rw);
      return (rw > 1) ? $clog2(rw) : 1;
   endfunction

   function automatic bit width_ok(input int w);
      return (w >= 4) && ((w % 2) == 0);
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: consumes two radicand bits, emits one root bit.
module isqrt_step #(
   parameter int RW = 8
) (
   input  logic [RW+1:0] p,
   input  logic [RW-1:0] q,
   input  logic [1:0]    xb,
   output logic [RW+1:0] p_nxt,
   output logic [RW-1:0] q_nxt
);

   logic [RW+1:0] pp;
   logic [RW+1:0] t;
   logic [RW+1:0] diff;
   logic          ge;

   // P never exceeds 2Q, so the bits shifted out of the top are always zero.
   assign pp    = (p << 2) | {{RW{1'b0}}, xb};
   assign t     = {q, 2'b01};
   assign ge    = (pp >= t);
   assign diff  = pp - t;
   assign p_nxt = ge ? diff : pp;
   assign q_nxt = {q[RW-2:0], ge};

endmodule

// File: rtl/isqrt_iter.sv
// Iterative floor/round-to-nearest integer square root, one root bit per clock,
// with back-to-back request acceptance on the done cycle.
module isqrt_iter
   import isqrt_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int RW    = WIDTH / 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             go,
   input  logic             rnd,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [RW-1:0]    root,
   output logic [RW:0]      rem,
   output logic             sat
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $fatal(1, "isqrt_iter: WIDTH must be even and >= 4");
   end

   localparam int             CW   = cnt_w(RW);
   localparam logic [CW-1:0]  LAST = CW'(RW - 1);

   state_t           state;
   logic [WIDTH-1:0] x;
   logic             r;
   logic [RW-1:0]    q;
   logic [RW+1:0]    p;
   logic [CW-1:0]    cnt;

   logic [RW+1:0]    p_nxt;
   logic [RW-1:0]    q_nxt;
   logic             up;

   isqrt_step #(.RW(RW)) u_step (
      .p     (p),
      .q     (q),
      .xb    (x[WIDTH-1:WIDTH-2]),
      .p_nxt (p_nxt),
      .q_nxt (q_nxt)
   );

   // Remainder above Q means x >= Q^2+Q+1, i.e. sqrt(x) >= Q+0.5.
   assign up   = r && (p > {2'b00, q});
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         x     <= '0;
         r     <= 1'b0;
         q     <= '0;
         p     <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         root  <= '0;
         rem   <= '0;
         sat   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  x     <= din;
                  r     <= rnd;
                  q     <= '0;
                  p     <= '0;
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               p   <= p_nxt;
               q   <= q_nxt;
               x   <= {x[WIDTH-3:0], 2'b00};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIN;
            end
            FIN: begin
               rem <= p[RW:0];
               if (up && (&q)) begin
                  root <= '1;
                  sat  <= 1'b1;
               end else if (up) begin
                  root <= q + 1'b1;
                  sat  <= 1'b0;
               end else begin
                  root <= q;
                  sat  <= 1'b0;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isqrt_iter.sv
// Self-checking bench: three widths (8/16/32) against an arithmetic sqrt model.
module tb_isqrt_iter;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   logic        go8, rnd8, busy8, done8, sat8;
   logic [7:0]  din8;
   logic [3:0]  root8;
   logic [4:0]  rem8;
   logic        go16, rnd16, busy16, done16, sat16;
   logic [15:0] din16;
   logic [7:0]  root16;
   logic [8:0]  rem16;
   logic        go32, rnd32, busy32, done32, sat32;
   logic [31:0] din32;
   logic [15:0] root32;
   logic [16:0] rem32;

   isqrt_iter #(.WIDTH(8)) u8 (
      .clk(clk), .clr(clr), .go(go8), .rnd(rnd8), .din(din8),
      .busy(busy8), .done(done8), .root(root8), .rem(rem8), .sat(sat8));
   isqrt_iter #(.WIDTH(16)) u16 (
      .clk(clk), .clr(clr), .go(go16), .rnd(rnd16), .din(din16),
      .busy(busy16), .done(done16), .root(root16), .rem(rem16), .sat(sat16));
   isqrt_iter #(.WIDTH(32)) u32 (
      .clk(clk), .clr(clr), .go(go32), .rnd(rnd32), .din(din32),
      .busy(busy32), .done(done32), .root(root32), .rem(rem32), .sat(sat32));

   typedef struct {
      longint root;
      longint rem;
      bit     sat;
   } exp_t;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;
   exp_t   q8[$], q16[$], q32[$];
   longint stim_d[$];
   bit     stim_r[$];
   exp_t   ce;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Reference: binary search for the largest s with s*s <= x; nearest rounding
   // decided by comparing 4x against (2s+1)^2.
   function automatic void model(input longint x, input int rw, input bit r,
                                 output longint root, output longint rem, output bit sat);
      longint lo, hi, mid, mx;
      mx = (longint'(1) << rw) - 1;
      lo = 0;
      hi = mx;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= x) lo = mid;
         else hi = mid - 1;
      end
      root = lo;
      rem  = x - lo * lo;
      sat  = 1'b0;
      if (r && (4 * x >= (2 * lo + 1) * (2 * lo + 1))) begin
         if (lo == mx) sat = 1'b1;
         else root = lo + 1;
      end
   endfunction

   task automatic push_exp(input int w, input longint d, input bit r);
      exp_t e;
      longint dm;
      dm = d & ((longint'(1) << w) - 1);
      model(dm, w / 2, r, e.root, e.rem, e.sat);
      case (w)
         8:       q8.push_back(e);
         16:      q16.push_back(e);
         default: q32.push_back(e);
      endcase
   endtask

   task automatic drive(input int w, input bit g, input longint d, input bit r);
      case (w)
         8:       begin go8  = g; din8  = d[7:0];  rnd8  = r; end
         16:      begin go16 = g; din16 = d[15:0]; rnd16 = r; end
         default: begin go32 = g; din32 = d[31:0]; rnd32 = r; end
      endcase
   endtask

   function automatic bit get_done(input int w);
      case (w)
         8:       return done8;
         16:      return done16;
         default: return done32;
      endcase
   endfunction

   // Streams stim_d/stim_r with go held high; each next request is offered in
   // the done cycle, and busy cycles are filled with random go/din/rnd noise.
   task automatic burst(input int w, input bit noise);
      int     n, rw, waited;
      longint tcap;
      n  = stim_d.size();
      rw = w / 2;
      @(negedge clk);
      drive(w, 1'b1, stim_d[0], stim_r[0]);
      push_exp(w, stim_d[0], stim_r[0]);
      tcap = cyc + 1;
      for (int i = 0; i < n; i++) begin
         waited = 0;
         do begin
            @(posedge clk);
            #1;
            waited++;
            if (!get_done(w) && noise)
               drive(w, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         end while (!get_done(w) && waited < 4 * rw + 8);
         if (!get_done(w)) begin
            flag($sformatf("timeout_w%0d req=%0d", w, i));
            drive(w, 1'b0, 0, 1'b0);
            return;
         end
         chk($sformatf("latency_w%0d", w), cyc - tcap, longint'(rw + 1));
         if (i < n - 1) begin
            drive(w, 1'b1, stim_d[i+1], stim_r[i+1]);
            push_exp(w, stim_d[i+1], stim_r[i+1]);
            tcap = cyc + 1;
         end else begin
            drive(w, 1'b0, 0, 1'b0);
         end
      end
   endtask

   task automatic single(input int w, input longint d, input bit r);
      stim_d.delete();
      stim_r.delete();
      stim_d.push_back(d);
      stim_r.push_back(r);
      burst(w, 1'b0);
   endtask

   // Compare process: every done pulse is matched against the model queue.
   always @(negedge clk) begin
      if (clr) begin
         if (done8) begin
            chk("busy_with_done8", longint'(busy8), 0);
            if (q8.size() == 0) flag("unexpected_done8");
            else begin
               ce = q8.pop_front();
               chk("root8", longint'(root8), ce.root);
               chk("rem8", longint'(rem8), ce.rem);
               chk("sat8", longint'(sat8), longint'(ce.sat));
            end
         end
         if (done16) begin
            chk("busy_with_done16", longint'(busy16), 0);
            if (q16.size() == 0) flag("unexpected_done16");
            else begin
               ce = q16.pop_front();
               chk("root16", longint'(root16), ce.root);
               chk("rem16", longint'(rem16), ce.rem);
               chk("sat16", longint'(sat16), longint'(ce.sat));
            end
         end
         if (done32) begin
            chk("busy_with_done32", longint'(busy32), 0);
            if (q32.size() == 0) flag("unexpected_done32");
            else begin
               ce = q32.pop_front();
               chk("root32", longint'(root32), ce.root);
               chk("rem32", longint'(rem32), ce.rem);
               chk("sat32", longint'(sat32), longint'(ce.sat));
            end
         end
      end
   end

   initial begin
      longint mr, mm;
      bit     ms;
      int     dcount;
      drive(8, 1'b0, 0, 1'b0);
      drive(16, 1'b0, 0, 1'b0);
      drive(32, 1'b0, 0, 1'b0);
      clr = 1'b1;
      #1 clr = 1'b0;
      #1;
      chk("rst_busy8", longint'(busy8), 0);
      chk("rst_done8", longint'(done8), 0);
      chk("rst_root8", longint'(root8), 0);
      chk("rst_rem8", longint'(rem8), 0);
      chk("rst_sat8", longint'(sat8), 0);
      chk("rst_busy32", longint'(busy32), 0);
      repeat (2) @(negedge clk);
      clr = 1'b1;

      // Pin the model itself with hand-computed values.
      model(200, 4, 1'b0, mr, mm, ms);
      chk("model_200_root", mr, 14);
      chk("model_200_rem", mm, 4);
      model(255, 4, 1'b1, mr, mm, ms);
      chk("model_255r_root", mr, 15);
      chk("model_255r_sat", longint'(ms), 1);
      model(211, 4, 1'b1, mr, mm, ms);
      chk("model_211r_root", mr, 15);

      // Directed WIDTH=8 vectors with literal expectations.
      single(8, 200, 1'b0);
      chk("d200_root", longint'(root8), 14);
      chk("d200_rem", longint'(rem8), 4);
      chk("d200_sat", longint'(sat8), 0);
      single(8, 210, 1'b1);
      chk("d210r_root", longint'(root8), 14);
      chk("d210r_rem", longint'(rem8), 14);
      single(8, 211, 1'b1);
      chk("d211r_root", longint'(root8), 15);
      chk("d211r_rem", longint'(rem8), 15);
      single(8, 255, 1'b1);
      chk("d255r_root", longint'(root8), 15);
      chk("d255r_rem", longint'(rem8), 30);
      chk("d255r_sat", longint'(sat8), 1);
      single(8, 0, 1'b0);
      chk("d0_root", longint'(root8), 0);
      chk("d0_rem", longint'(rem8), 0);
      single(8, 1, 1'b0);
      chk("d1_root", longint'(root8), 1);
      chk("d1_rem", longint'(rem8), 0);

      // WIDTH=16 extremes.
      single(16, 65535, 1'b0);
      chk("d65535_root", longint'(root16), 255);
      chk("d65535_rem", longint'(rem16), 510);
      single(16, 65025, 1'b0);
      chk("d65025_root", longint'(root16), 255);
      chk("d65025_rem", longint'(rem16), 0);

      // Back-to-back at WIDTH=16 with go held and noise while busy.
      stim_d = '{1000, 50000, 65535, 12345, 32768, 7};
      stim_r = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      burst(16, 1'b1);
      chk("b2b_last_root", longint'(root16), 2);
      chk("b2b_last_rem", longint'(rem16), 3);

      // Asynchronous reset during CALC iteration 3 aborts the request.
      @(negedge clk);
      drive(16, 1'b1, 40000, 1'b0);
      push_exp(16, 40000, 1'b0);
      @(posedge clk);
      #1 drive(16, 1'b0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #3 clr = 1'b0;
      #1;
      chk("abort_busy", longint'(busy16), 0);
      chk("abort_done", longint'(done16), 0);
      chk("abort_root", longint'(root16), 0);
      chk("abort_rem", longint'(rem16), 0);
      chk("abort_sat", longint'(sat16), 0);
      q16.delete();
      #9 clr = 1'b1;
      dcount = 0;
      repeat (20) begin
         @(posedge clk);
         #1 if (done16) dcount++;
      end
      chk("abort_no_done", longint'(dcount), 0);
      single(16, 40000, 1'b1);
      chk("post_abort_root", longint'(root16), 200);
      chk("post_abort_rem", longint'(rem16), 0);

      // Exhaustive WIDTH=8 sweep, both rounding modes.
      stim_d.delete();
      stim_r.delete();
      for (int x = 0; x < 256; x++) begin
         for (int rr = 0; rr < 2; rr++) begin
            stim_d.push_back(longint'(x));
            stim_r.push_back(rr[0]);
         end
      end
      burst(8, 1'b1);

      // Random WIDTH=32 vectors plus the top corners.
      stim_d.delete();
      stim_r.delete();
      stim_d.push_back(64'hFFFF_FFFF);
      stim_r.push_back(1'b1);
      stim_d.push_back(64'hFFFE_0001);
      stim_r.push_back(1'b1);
      for (int i = 0; i < 1500; i++) begin
         stim_d.push_back(longint'($urandom));
         stim_r.push_back(1'($urandom_range(0, 1)));
      end
      burst(32, 1'b1);

      repeat (4) @(negedge clk);
      chk("q8_drained", longint'(q8.size()), 0);
      chk("q16_drained", longint'(q16.size()), 0);
      chk("q32_drained", longint'(q32.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
